// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state encoding and helpers for the PWM duty controller.
// The optional auto-retry feature is selected with PWM_CTRL_AUTO_RETRY_EN.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    REGULATE  = 2'd2,
    FAULT     = 2'd3
  } pwm_state_e;

  // True in the states where the gate driver is enabled and duty is live.
  function automatic logic is_driving(input pwm_state_e s);
    return (s == SOFTSTART) || (s == REGULATE);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: regulation-rate prescaler. Counts 0..UPDATE_DIV-1 while run is
// high and flags tick on the last count. clr restarts the count so the first
// tick after a state change lands UPDATE_DIV cycles after state entry.
module pwm_tick_gen #(
  parameter int UPDATE_DIV = 10000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(UPDATE_DIV);
  localparam logic [CW-1:0] LAST = CW'(UPDATE_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: hold at zero when idle or cleared, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = run && (cnt_q == LAST);

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_controller.sv
// pwm_duty_controller: closed-loop sequencer owning the PWM duty word and the
// gate-driver enable: soft-start, bang-bang regulation, overcurrent shutdown.
// Define PWM_CTRL_AUTO_RETRY_EN to make FAULT restart by itself after
// RETRY_CYC quiet cycles; otherwise FAULT latches until start drops or reset.
module pwm_duty_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DW         = 11,
  parameter int UPDATE_DIV = 10000,
  parameter int DUTY_MAX   = 1900,
  parameter int SS_LIMIT   = 1024
`ifdef PWM_CTRL_AUTO_RETRY_EN
  ,
  parameter int RETRY_CYC  = 2000000
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          fb,
  input  logic          ocp,
  output logic [DW-1:0] duty,
  output logic          en,
  output logic          pgood,
  output logic          fault,
  output logic [1:0]    state
);

  localparam logic [DW-1:0] DUTY_MAX_W = DW'(DUTY_MAX);
  localparam logic [DW-1:0] SS_LIMIT_W = DW'(SS_LIMIT);

  pwm_state_e    state_q;
  pwm_state_e    state_d;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] duty_d;
  logic          en_q;
  logic          en_d;
  logic          tick;
  logic          tick_run;
  logic          tick_clr;

`ifdef PWM_CTRL_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_CYC);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_CYC - 1);

  logic [RW-1:0] retry_q;
  logic [RW-1:0] retry_d;
`endif

  // The prescaler only runs while driving and restarts on every state change.
  assign tick_run = is_driving(state_q);
  assign tick_clr = (state_d != state_q);

  pwm_tick_gen #(
    .UPDATE_DIV(UPDATE_DIV)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .clr  (tick_clr),
    .run  (tick_run),
    .tick (tick)
  );

  // Next state and duty: start=0 beats ocp, ocp beats the tick action.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    en_d    = 1'b0;
`ifdef PWM_CTRL_AUTO_RETRY_EN
    retry_d = '0;
`endif
    if (!start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SOFTSTART;
        end
        SOFTSTART: begin
          if (ocp) begin
            state_d = FAULT;
          end else if (tick) begin
            if (fb) begin
              state_d = REGULATE;
            end else if (duty_q < SS_LIMIT_W) begin
              duty_d = duty_q + 1'b1;
            end else begin
              state_d = FAULT;
            end
          end
        end
        REGULATE: begin
          if (ocp) begin
            state_d = FAULT;
          end else if (tick) begin
            if (fb) begin
              if (duty_q != '0) begin
                duty_d = duty_q - 1'b1;
              end
            end else if (duty_q < DUTY_MAX_W) begin
              duty_d = duty_q + 1'b1;
            end else begin
              duty_d = DUTY_MAX_W;
            end
          end
        end
        FAULT: begin
`ifdef PWM_CTRL_AUTO_RETRY_EN
          if (ocp) begin
            retry_d = '0;
          end else if (retry_q == RETRY_LAST) begin
            state_d = SOFTSTART;
          end else begin
            retry_d = retry_q + 1'b1;
          end
`else
          state_d = FAULT;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    if (!is_driving(state_d)) begin
      duty_d = '0;
    end
    en_d = is_driving(state_d);
  end

  // State, duty and enable registers; reset returns straight to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      en_q    <= en_d;
    end
  end

`ifdef PWM_CTRL_AUTO_RETRY_EN
  // Fault hold counter, only meaningful while in FAULT.
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign duty  = duty_q;
  assign en    = en_q;
  assign pgood = (state_q == REGULATE);
  assign fault = (state_q == FAULT);
  assign state = state_q;

endmodule
